// File: rtl/imem_pkg.sv
// Shared types and helpers for the synchronous instruction memory.
// Holds the mode-FSM state encoding and the byte-PC to word-index helper.
package imem_pkg;

    localparam logic [31:0] NOP_DEFAULT = 32'h0000_0000;
    localparam int          PC_MAX_W    = 64;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2
    } imem_state_t;

    // PCs are widened to PC_MAX_W first so one helper serves any ADDR_W up to 64.
    function automatic logic [PC_MAX_W-1:0] word_index(input logic [PC_MAX_W-1:0] pc);
        return {2'b00, pc[PC_MAX_W-1:2]};
    endfunction

endpackage

// File: rtl/imem_array.sv
// Single-write, single-synchronous-read instruction storage without reset.
// The read register only updates when re is high, so it holds across stalls.
module imem_array
    import imem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/instruction_memory_sync.sv
// Fetch-stage instruction memory: registered read, stall/flush, fault flags,
// and an in-system program-load port gated by a RUN/LOAD/DRAIN mode machine.
module instruction_memory_sync
    import imem_pkg::*;
#(
    parameter int                DATA_W    = 32,
    parameter int                ADDR_W    = 32,
    parameter int                DEPTH     = 64,
    parameter logic [DATA_W-1:0] NOP_INSTR = DATA_W'(NOP_DEFAULT)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [ADDR_W-1:0]        pc_i,
    input  logic                     rd_en,
    input  logic                     stall,
    input  logic                     flush,
    input  logic                     ld_en,
    input  logic                     ld_we,
    input  logic [$clog2(DEPTH)-1:0] ld_addr,
    input  logic [DATA_W-1:0]        ld_data,
    output logic [DATA_W-1:0]        instr_o,
    output logic                     instr_valid,
    output logic                     fault_misaligned,
    output logic                     fault_range,
    output logic                     ld_busy,
    output logic [$clog2(DEPTH):0]   ld_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    imem_state_t         state;
    imem_state_t         state_next;
    logic [PC_MAX_W-1:0] pc_ext;
    logic [PC_MAX_W-1:0] word_idx;
    logic                misaligned;
    logic                out_of_range;
    logic                valid_next;
    logic                fm_next;
    logic                fr_next;
    logic                rd_fire;
    logic                mem_we;
    logic                mem_re;
    logic [DATA_W-1:0]   mem_rdata;

    assign pc_ext       = PC_MAX_W'(pc_i);
    assign word_idx     = word_index(pc_ext);
    assign misaligned   = (pc_i[1:0] != 2'b00);
    assign out_of_range = (word_idx >= PC_MAX_W'(DEPTH));

    // Mode transitions plus the RUN-state fetch priority: flush, stall, faults, read.
    always_comb begin
        state_next = state;
        valid_next = 1'b0;
        fm_next    = 1'b0;
        fr_next    = 1'b0;
        rd_fire    = 1'b0;
        case (state)
            RUN: begin
                if (ld_en) begin
                    state_next = LOAD;
                end else if (flush) begin
                    valid_next = 1'b0;
                end else if (stall) begin
                    valid_next = instr_valid;
                    fm_next    = fault_misaligned;
                    fr_next    = fault_range;
                end else if (rd_en) begin
                    if (misaligned) begin
                        fm_next = 1'b1;
                    end else if (out_of_range) begin
                        fr_next = 1'b1;
                    end else begin
                        rd_fire    = 1'b1;
                        valid_next = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (!ld_en) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                state_next = RUN;
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= RUN;
            instr_valid      <= 1'b0;
            fault_misaligned <= 1'b0;
            fault_range      <= 1'b0;
        end else begin
            state            <= state_next;
            instr_valid      <= valid_next;
            fault_misaligned <= fm_next;
            fault_range      <= fr_next;
        end
    end

    // Counts accepted load writes since entering LOAD; sticks at DEPTH.
    always_ff @(posedge clk) begin
        if (reset) begin
            ld_count <= '0;
        end else if (state == RUN && ld_en) begin
            ld_count <= '0;
        end else if (mem_we && ld_count != CW'(DEPTH)) begin
            ld_count <= ld_count + CW'(1);
        end
    end

    assign mem_we = (state == LOAD) && ld_en && ld_we && !reset;
    assign mem_re = rd_fire && !reset;

    imem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .waddr (ld_addr),
        .wdata (ld_data),
        .re    (mem_re),
        .raddr (word_idx[AW-1:0]),
        .rdata (mem_rdata)
    );

    // The array's read register is only trusted while instr_valid is set.
    assign instr_o = instr_valid ? mem_rdata : NOP_INSTR;
    assign ld_busy = (state != RUN);

endmodule

// File: tb/tb_instruction_memory_sync.sv
// Scoreboard bench for instruction_memory_sync: each task drives one scenario,
// pushes predicted fetch results, and compares them one cycle later.
module tb_instruction_memory_sync;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int DEPTH  = 64;
    localparam int AW     = $clog2(DEPTH);

    typedef struct packed {
        logic [DATA_W-1:0] instr;
        logic              valid;
        logic              fm;
        logic              fr;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset;
    logic [ADDR_W-1:0] pc_i;
    logic              rd_en, stall, flush, ld_en, ld_we;
    logic [AW-1:0]     ld_addr;
    logic [DATA_W-1:0] ld_data;
    logic [DATA_W-1:0] instr_o;
    logic              instr_valid, fault_misaligned, fault_range, ld_busy;
    logic [AW:0]       ld_count;

    int n_checks = 0;
    int n_fail   = 0;

    exp_t              sb_q[$];
    exp_t              m_prev;
    logic [DATA_W-1:0] model_mem [DEPTH];
    localparam exp_t   EXP_NOP = '{instr: '0, valid: 1'b0, fm: 1'b0, fr: 1'b0};

    always #5 clk = ~clk;

    instruction_memory_sync #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .DEPTH     (DEPTH),
        .NOP_INSTR (32'h0000_0000)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .pc_i             (pc_i),
        .rd_en            (rd_en),
        .stall            (stall),
        .flush            (flush),
        .ld_en            (ld_en),
        .ld_we            (ld_we),
        .ld_addr          (ld_addr),
        .ld_data          (ld_data),
        .instr_o          (instr_o),
        .instr_valid      (instr_valid),
        .fault_misaligned (fault_misaligned),
        .fault_range      (fault_range),
        .ld_busy          (ld_busy),
        .ld_count         (ld_count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference fetch behaviour for one RUN-state edge.
    function automatic exp_t predict(input logic rd, input logic [ADDR_W-1:0] pc,
                                     input logic st, input logic fl);
        exp_t e;
        e = EXP_NOP;
        if (fl) e = EXP_NOP;
        else if (st) e = m_prev;
        else if (rd) begin
            if (pc[1:0] != 2'b00) e.fm = 1'b1;
            else if ((pc >> 2) >= DEPTH) e.fr = 1'b1;
            else begin
                e.instr = model_mem[pc[AW+1:2]];
                e.valid = 1'b1;
            end
        end
        return e;
    endfunction

    task automatic drive_fetch(input logic rd, input logic [ADDR_W-1:0] pc,
                               input logic st, input logic fl);
        exp_t e;
        rd_en = rd; pc_i = pc; stall = st; flush = fl;
        e = predict(rd, pc, st, fl);
        sb_q.push_back(e);
        m_prev = e;
    endtask

    task automatic push_nop();
        sb_q.push_back(EXP_NOP);
        m_prev = EXP_NOP;
    endtask

    task automatic test_reset();
        exp_t obs, e;
        reset = 1'b1; rd_en = 0; stall = 0; flush = 0; ld_en = 0; ld_we = 0;
        pc_i = '0; ld_addr = '0; ld_data = '0;
        step();
        step();
        push_nop();
        e = sb_q.pop_front();
        obs = '{instr_o, instr_valid, fault_misaligned, fault_range};
        n_checks++;
        if (obs !== e) begin
            n_fail++;
            $display("[TB] FAIL reset_outputs got=%h want=%h", obs, e);
        end
        n_checks++;
        if ({ld_busy, ld_count} !== {1'b0, 7'd0}) begin
            n_fail++;
            $display("[TB] FAIL reset_ld got busy=%b count=%0d want busy=0 count=0", ld_busy, ld_count);
        end
        reset = 1'b0;
    endtask

    task automatic test_load();
        ld_en = 1'b1;
        step();
        n_checks++;
        if ({ld_busy, ld_count} !== {1'b1, 7'd0}) begin
            n_fail++;
            $display("[TB] FAIL load_enter got busy=%b count=%0d want busy=1 count=0", ld_busy, ld_count);
        end
        ld_we = 1'b1; ld_addr = 0; ld_data = 32'h1111_1111;
        model_mem[0] = 32'h1111_1111;
        step();
        ld_addr = 1; ld_data = 32'h2222_2222;
        model_mem[1] = 32'h2222_2222;
        step();
        n_checks++;
        if (ld_count !== 7'd2) begin
            n_fail++;
            $display("[TB] FAIL load_count got=%0d want=2", ld_count);
        end
        ld_en = 1'b0; ld_we = 1'b0;
        step();
        n_checks++;
        if (ld_busy !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL drain_busy got=%b want=1", ld_busy);
        end
        step();
        n_checks++;
        if ({ld_busy, ld_count} !== {1'b0, 7'd2}) begin
            n_fail++;
            $display("[TB] FAIL run_after_drain got busy=%b count=%0d want busy=0 count=2", ld_busy, ld_count);
        end
        m_prev = EXP_NOP;
    endtask

    task automatic test_pipelined_fetch();
        exp_t obs, e;
        logic [ADDR_W-1:0] pcs [3];
        pcs[0] = 32'h0; pcs[1] = 32'h4; pcs[2] = 32'h0;
        for (int i = 0; i < 3; i++) begin
            drive_fetch(1'b1, pcs[i], 1'b0, 1'b0);
            step();
            e = sb_q.pop_front();
            obs = '{instr_o, instr_valid, fault_misaligned, fault_range};
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("[TB] FAIL fetch_pc%h got=%h want=%h", pcs[i], obs, e);
            end
        end
    endtask

    task automatic test_stall_flush();
        exp_t obs, e;
        logic [2:0] ctl [6];
        // {rd_en, stall, flush}; pc alternates to prove the held output ignores it
        ctl[0] = 3'b100; ctl[1] = 3'b110; ctl[2] = 3'b110;
        ctl[3] = 3'b110; ctl[4] = 3'b111; ctl[5] = 3'b010;
        for (int i = 0; i < 6; i++) begin
            drive_fetch(ctl[i][2], (i == 0) ? 32'h4 : 32'h0, ctl[i][1], ctl[i][0]);
            step();
            e = sb_q.pop_front();
            obs = '{instr_o, instr_valid, fault_misaligned, fault_range};
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("[TB] FAIL stall_flush_step%0d got=%h want=%h", i, obs, e);
            end
        end
    endtask

    task automatic test_faults();
        exp_t obs, e;
        logic [ADDR_W-1:0] pcs [7];
        logic              rds [7];
        logic              sts [7];
        pcs[0] = 32'h6;   rds[0] = 1; sts[0] = 0;
        pcs[1] = 32'h100; rds[1] = 1; sts[1] = 0;
        pcs[2] = 32'h102; rds[2] = 1; sts[2] = 0;
        pcs[3] = 32'h0;   rds[3] = 1; sts[3] = 1;
        pcs[4] = 32'hFC;  rds[4] = 1; sts[4] = 0;
        pcs[5] = 32'hF8;  rds[5] = 1; sts[5] = 0;
        pcs[6] = 32'h0;   rds[6] = 0; sts[6] = 0;
        model_mem[62] = 32'h0;
        for (int i = 0; i < 7; i++) begin
            if (i == 5) continue;
            drive_fetch(rds[i], pcs[i], sts[i], 1'b0);
            step();
            e = sb_q.pop_front();
            obs = '{instr_o, instr_valid, fault_misaligned, fault_range};
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("[TB] FAIL fault_pc%h got=%h want=%h", pcs[i], obs, e);
            end
        end
    endtask

    task automatic test_saturation_isolation();
        exp_t obs, e;
        rd_en = 1'b0; stall = 1'b0; flush = 1'b0;
        ld_en = 1'b1; ld_we = 1'b0;
        step();
        push_nop();
        void'(sb_q.pop_front());
        for (int i = 0; i < DEPTH + 3; i++) begin
            ld_we = 1'b1;
            ld_addr = AW'(i % DEPTH);
            ld_data = 32'hA000_0000 + i;
            model_mem[i % DEPTH] = 32'hA000_0000 + i;
            rd_en = 1'b1; pc_i = 32'h0;
            push_nop();
            step();
            if (i == 4) begin
                e = sb_q.pop_front();
                obs = '{instr_o, instr_valid, fault_misaligned, fault_range};
                n_checks++;
                if (obs !== e) begin
                    n_fail++;
                    $display("[TB] FAIL load_isolation got=%h want=%h", obs, e);
                end
            end else begin
                void'(sb_q.pop_front());
            end
        end
        n_checks++;
        if (ld_count !== 7'(DEPTH)) begin
            n_fail++;
            $display("[TB] FAIL count_saturate got=%0d want=%0d", ld_count, DEPTH);
        end
        ld_en = 1'b0; ld_we = 1'b1; ld_addr = 5; ld_data = 32'hDEAD_BEEF;
        step();
        ld_we = 1'b0; rd_en = 1'b1; pc_i = 32'h14;
        push_nop();
        step();
        e = sb_q.pop_front();
        obs = '{instr_o, instr_valid, fault_misaligned, fault_range};
        n_checks++;
        if (obs !== e) begin
            n_fail++;
            $display("[TB] FAIL drain_isolation got=%h want=%h", obs, e);
        end
        drive_fetch(1'b1, 32'h14, 1'b0, 1'b0);
        step();
        e = sb_q.pop_front();
        obs = '{instr_o, instr_valid, fault_misaligned, fault_range};
        n_checks++;
        if (obs !== e) begin
            n_fail++;
            $display("[TB] FAIL exit_write_dropped got=%h want=%h", obs, e);
        end
        drive_fetch(1'b1, 32'h4, 1'b0, 1'b0);
        step();
        e = sb_q.pop_front();
        obs = '{instr_o, instr_valid, fault_misaligned, fault_range};
        n_checks++;
        if (obs !== e) begin
            n_fail++;
            $display("[TB] FAIL wrapped_write got=%h want=%h", obs, e);
        end
    endtask

    task automatic test_reset_mid_load();
        exp_t obs, e;
        rd_en = 1'b0; ld_en = 1'b1; ld_we = 1'b0;
        step();
        ld_we = 1'b1; ld_addr = 7; ld_data = 32'h7777_7777;
        model_mem[7] = 32'h7777_7777;
        step();
        reset = 1'b1; ld_addr = 8; ld_data = 32'hBAD0_BAD0;
        step();
        reset = 1'b0; ld_en = 1'b0; ld_we = 1'b0;
        m_prev = EXP_NOP;
        n_checks++;
        if ({ld_busy, ld_count} !== {1'b0, 7'd0}) begin
            n_fail++;
            $display("[TB] FAIL reset_mid_load got busy=%b count=%0d want busy=0 count=0", ld_busy, ld_count);
        end
        for (int i = 0; i < 2; i++) begin
            drive_fetch(1'b1, (i == 0) ? 32'h20 : 32'h1C, 1'b0, 1'b0);
            step();
            e = sb_q.pop_front();
            obs = '{instr_o, instr_valid, fault_misaligned, fault_range};
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("[TB] FAIL reset_load_readback%0d got=%h want=%h", i, obs, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_pipelined_fetch();
        test_stall_flush();
        test_faults();
        test_saturation_isolation();
        test_reset_mid_load();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instruction_memory_sync.md
Name: instruction_memory_sync

Overview:
Parametrised, synchronous-read instruction memory for the pipelined processor's fetch stage. It replaces the fixed 32x32 asynchronous ROM with a configurable-depth array that has:
- a registered read (1-cycle latency),
- stall and flush handling,
- an in-system program-load port guarded by a small mode state machine,
- alignment and range fault flags.

Fetch presents a byte PC; decode receives a registered instruction plus a valid bit.

Parameters:
DATA_W, 32, instruction width in bits
ADDR_W, 32, PC/byte-address width
DEPTH, 64, number of instruction words (power of 2, >=2)
NOP_INSTR, 32'h00000000, value driven on instr_o when no valid instruction

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
pc_i  in  ADDR_W  byte address of the instruction to fetch
rd_en  in  1  fetch request this cycle
stall  in  1  hold the current fetch output (pipeline stall)
flush  in  1  kill the in-flight fetch (branch/jump taken)
ld_en  in  1  request program-load mode
ld_we  in  1  write strobe, honoured only in LOAD state
ld_addr  in  $clog2(DEPTH)  word index for a load write
ld_data  in  DATA_W  word to write
instr_o  out  DATA_W  registered instruction
instr_valid  out  1  instr_o holds a real fetched instruction
fault_misaligned  out  1  registered: last accepted fetch had pc_i[1:0]!=0
fault_range  out  1  registered: last accepted fetch word index >= DEPTH
ld_busy  out  1  high in LOAD or DRAIN state
ld_count  out  $clog2(DEPTH)+1  words written since entering LOAD, saturating at DEPTH

Behaviour:
Interface: one clock; reset is synchronous and active-high; ports named clk and reset.

Reset, sampled on a clk edge with reset=1:
- state <= RUN
- instr_o <= NOP_INSTR
- instr_valid, fault_misaligned, fault_range <= 0
- ld_count <= 0
- Array contents are not cleared.
- Reset overrides every other input, including mid-load; a write presented in the reset cycle is dropped.

State machine states: RUN, LOAD, DRAIN. ld_busy = (state != RUN).
- RUN -> LOAD when ld_en=1. Fetch inputs are ignored in that cycle: instr_o <= NOP_INSTR, instr_valid <= 0, ld_count <= 0.
- LOAD -> LOAD while ld_en=1:
  - ld_we=1 writes ld_data to mem[ld_addr].
  - ld_count increments, saturating at DEPTH.
- LOAD -> DRAIN when ld_en=0. A write with ld_we=1 in this cycle is ignored.
- DRAIN -> RUN unconditionally after one cycle. instr_o is NOP, instr_valid=0.
- In LOAD and DRAIN, fetch inputs, stall and flush are ignored. Outputs hold NOP, valid=0 and faults=0.

RUN fetch priority per edge (highest first):
1. flush=1: instr_o <= NOP_INSTR, instr_valid <= 0, faults <= 0. Flush beats stall.
2. stall=1: instr_o, instr_valid and faults all hold.
3. rd_en=1 with pc_i[1:0]!=0: NOP, valid=0, fault_misaligned <= 1, fault_range <= 0.
4. rd_en=1 with word index pc_i[ADDR_W-1:2] >= DEPTH: NOP, valid=0, fault_range <= 1.
5. rd_en=1, otherwise: instr_o <= mem[pc_i[2+:log2 DEPTH]], instr_valid <= 1, faults <= 0.
6. rd_en=0: NOP, valid=0, faults <= 0.

Timing and ordering:
- Read latency is exactly 1 cycle: instruction for the PC sampled at edge N is visible after edge N.
- Misaligned takes precedence over range when both apply.
- Fault flags are single-cycle results tied to the fetch, not sticky.
- Read-during-write cannot occur, because reads are blocked outside RUN.

Decomposition:
Shared package imem_pkg holds:
- NOP_INSTR default
- state enum {RUN, LOAD, DRAIN}
- function for word-index extraction from a byte PC

Sub-module imem_array: single-write, single-synchronous-read RAM (DATA_W x DEPTH), read-enable gated, no reset. The top level contains the FSM, priority mux, fault logic and counter.

Test Plan:
1. Reset, load and fetch: assert reset 2 cycles -> instr_o=0, valid=0, ld_busy=0. Then ld_en=1, write 0x11111111 @0 and 0x22222222 @1 -> ld_count=2. Drop ld_en -> one DRAIN cycle with ld_busy=1, then ld_busy=0.
2. Pipelined fetch: rd_en=1 with pc=0x0 then 0x4 -> instr_o 0x11111111 then 0x22222222, each 1 cycle after presentation, valid=1.
3. Stall/flush: with pc=0x4 fetched, stall=1 for 3 cycles -> instr_o holds 0x22222222, valid=1. Then stall=1 and flush=1 together -> instr_o=0, valid=0.
4. Faults: pc=0x6 -> fault_misaligned=1, valid=0. pc=0x100 with DEPTH=64 -> fault_range=1. pc=0x102 -> only fault_misaligned=1.
5. Saturation and mode isolation: write DEPTH+3 words in LOAD -> ld_count=DEPTH. rd_en=1 during LOAD -> valid stays 0. ld_we in the LOAD-exit cycle is not written (readback shows old data).
6. Reset mid-load: reset asserted while in LOAD with ld_we=1 -> state RUN, ld_count=0, that word not written.
